// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and helpers for the chunk-serial adder/subtractor.
//   state_e      : controller states (idle, chunk loop, one-cycle result)
//   calc_nchunk  : number of chunks an operand is split into
//   chunk_fits   : elaboration-time legality check of the WIDTH/CHUNK pair
package seq_chunk_adder_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  function automatic int unsigned calc_nchunk(input int unsigned width,
                                              input int unsigned chunk);
    return width / chunk;
  endfunction

  function automatic bit chunk_fits(input int unsigned width, input int unsigned chunk);
    return (chunk != 0) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/seq_chunk_adder_if.sv
// Request/result bundle of seq_chunk_adder.
//   start, sub, a, b, cin : request side (driven by master)
//   busy, done, sum, cout, ovf : status/result side (driven by slave)
interface seq_chunk_adder_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/seq_chunk_adder_chunk_adder.sv
// Combinational CHUNK-bit adder slice.
//   a_i, b_i : chunk operands        c_i     : carry in
//   s_o      : chunk sum             co_o    : carry out of the top bit
//   c_msb_o  : carry into the top bit (for signed overflow on the last chunk)
module chunk_adder #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             c_i,
  output logic [CHUNK-1:0] s_o,
  output logic             co_o,
  output logic             c_msb_o
);

  logic [CHUNK:0] full;

  always_comb begin
    full    = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, c_i};
    s_o     = full[CHUNK-1:0];
    co_o    = full[CHUNK];
    // Sum bit = a ^ b ^ carry_in, so the carry into the top bit falls out directly.
    c_msb_o = full[CHUNK-1] ^ a_i[CHUNK-1] ^ b_i[CHUNK-1];
  end

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: adds or subtracts WIDTH-bit operands CHUNK bits per
// cycle through a single reused chunk_adder, carrying between chunks in a register.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of seq_chunk_adder_if (start/sub/a/b/cin in,
//           busy/done/sum/cout/ovf out)
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input logic              clk,
  input logic              rst_n,
  seq_chunk_adder_if.slave bus
);

  localparam int unsigned NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int unsigned IdxW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (!chunk_fits(WIDTH, CHUNK)) begin : g_param_check
    $error("seq_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;       // effective B (already inverted for subtract)
  logic             carry_q, carry_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] res_q, res_d;   // partial result, built chunk by chunk
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
  logic             co, c_msb, last;

  assign a_chunk = a_q[idx_q * CHUNK +: CHUNK];
  assign b_chunk = b_q[idx_q * CHUNK +: CHUNK];
  assign last    = (idx_q == IdxW'(NCHUNK - 1));

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .a_i     (a_chunk),
    .b_i     (b_chunk),
    .c_i     (carry_q),
    .s_o     (s_chunk),
    .co_o    (co),
    .c_msb_o (c_msb)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ^ bus.cin;  // subtract: a + ~b + ~borrow_in
          idx_d   = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        res_d[idx_q * CHUNK +: CHUNK] = s_chunk;
        carry_d = co;
        idx_d   = idx_q + 1'b1;
        if (last) begin
          idx_d   = '0;
          sum_d   = res_d;
          cout_d  = co;
          ovf_d   = co ^ c_msb;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = (state_q == StRun);
  assign bus.done = (state_q == StDone);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule
